kamacore_stage_mem: RTL
=======================

// Module: kamacore_stage_mem
// PURPOSE
//  Memory stage: consumes the EX/MEM pipeline register and drives the data-memory
//  request/response port for loads and stores. Produces the MEM/WB pipeline register.
//  Stalls upstream stages while a memory access is outstanding.
//  Non-memory instructions pass the ALU result through with 1-cycle latency.
// PARAMETERS
//  ADDR_WIDTH   32   data-memory byte address width (<= CPU_WIDTH)
//  RSP_TIMEOUT  255  max cycles in WAIT_RSP before bus error; 8-bit counter; must be 1..255
// PORTS
//  clk                     in   1          rising-edge clock
//  rst                     in   1          asynchronous, active-low reset
//  ex_mem_valid            in   1          EX/MEM holds a valid instruction
//  ex_mem_alu_result       in   CPU_WIDTH  ALU result / effective address
//  ex_mem_rs2_data         in   CPU_WIDTH  store data
//  ex_mem_instruction      in   32         instruction word; funct3 = [14:12]
//  ex_mem_control_signals  in   ctrl_t     mem_read, mem_write, reg_write, ...
//  stall                   out  1          hold EX/MEM and earlier stages stable
//  dmem_req_valid          out  1          request valid
//  dmem_req_ready          in   1          request accepted when valid&ready
//  dmem_req_addr           out  ADDR_WIDTH word-aligned address ({addr[W-1:2],2'b00})
//  dmem_req_we             out  1          1 = store
//  dmem_req_be             out  4          byte enables
//  dmem_req_wdata          out  CPU_WIDTH  lane-aligned store data
//  dmem_rsp_valid          in   1          load data valid (single-cycle pulse)
//  dmem_rsp_rdata          in   CPU_WIDTH  raw load word
//  mem_wb_valid            out  1          MEM/WB holds a valid instruction
//  mem_wb_result           out  CPU_WIDTH  load data or ALU result
//  mem_wb_instruction      out  32         forwarded instruction
//  mem_wb_control_signals  out  ctrl_t     forwarded control
//  mem_wb_bus_err          out  1          access timed out
// BEHAVIOUR
//  - Reset: state=IDLE, timeout counter=0, every mem_wb_* output=0. Request outputs are
//    combinational from state and inputs; they are 0 whenever ex_mem_valid=0.
//  - FSM states: IDLE, WAIT_RSP.
//  - IDLE with non-mem op (or valid=0): MEM/WB loads inputs (result=alu_result); stall=0.
//  - IDLE with mem op: dmem_req_valid=1 and the request is stable until accepted.
//    - Store accepted: mem_wb_valid=1 at the next edge; FSM stays in IDLE (posted write).
//    - Load accepted: go to WAIT_RSP.
//  - WAIT_RSP: dmem_req_valid=0. On dmem_rsp_valid, extract data and load MEM/WB; go to IDLE.
//    - Extraction by funct3 and addr[1:0]: LB/LBU select a byte, LH/LHU select a half
//      (addr[1]), LW takes the whole word.
//    - LB/LH sign-extend; LBU/LHU zero-extend.
//  - stall = mem op present & ~(store accepted this cycle | rsp_valid in WAIT_RSP
//    | timeout this cycle). Completion drops stall in the same cycle.
//  - mem_wb_valid is 0 in every cycle while stall=1 (bubble): exactly one valid per instruction.
//  - Latency: store with ready=1 takes 1 cycle. Load with ready=1 and rsp the next cycle
//    takes 2 cycles.
//  - Store lanes:
//    - SB: be=4'b0001<<addr[1:0]; wdata = byte replicated x4.
//    - SH: be=addr[1]?1100:0011; wdata = half replicated x2.
//    - SW: be=1111.
//  - Timeout: the counter increments in WAIT_RSP. When it reaches RSP_TIMEOUT, complete
//    with result=0, bus_err=1, go to IDLE. The counter clears on leaving WAIT_RSP.
//  - dmem_rsp_valid in IDLE is ignored (late or stray response).
//  - Reset mid-access: FSM and outputs return to reset values. A response arriving
//    afterwards is ignored.
// CONFIGURATION
//  KAMACORE_MEM_MISALIGN_TRAP_EN defined:
//    - Misaligned LH/LHU/SH (addr[0]) or LW/SW (addr[1:0]!=0) issues no request.
//    - MEM/WB loads next edge with result=alu_result (the bad address), mem_wb_misaligned=1
//      (extra output port). Stores write nothing.
//  Undefined:
//    - Offending low address bits are forced to 0 (half: addr[0]; word: addr[1:0]).
//    - The access proceeds normally; no extra port.
// STRUCTURE
//  - kamacore_pkg: ctrl_t fields mem_read/mem_write; funct3 localparams
//    F3_LB/LH/LW/LBU/LHU/SB/SH/SW; mem_state_e {IDLE, WAIT_RSP}.
//  - One sub-module: kamacore_load_align. Combinational; (rdata, addr[1:0], funct3) ->
//    extended result. Instantiated once.
// TESTING
//  - ALU op (ADD, alu_result=32'h1234): stall=0; next edge mem_wb_result=32'h1234, valid=1.
//  - SB addr=0x103, rs2=0xAB, ready=1: be=1000, wdata=0xABABABAB, addr=0x100;
//    one mem_wb_valid, no stall.
//  - LB addr=0x101, ready low 3 cycles, rsp rdata=0x00008000 two cycles later:
//    result=0xFFFFFF80 (LB byte1); LBU gives 0x00000080. stall high until the rsp cycle.
//  - LW with no rsp: bus_err=1 and result=0 after RSP_TIMEOUT cycles; later stray rsp ignored.
//  - Assert rst low in WAIT_RSP: all outputs 0 immediately, state IDLE.
//  - LH addr=0x201: with _EN defined, misaligned=1 and no dmem_req_valid. Without it,
//    the request goes to addr 0x200 and the lower half is returned.

Source files
------------

// File: rtl/kamacore_pkg.sv
// Shared types and constants for the kamacore memory stage.
// Control word layout, load/store funct3 encodings and the memory FSM states.
package kamacore_pkg;

    localparam int CPU_WIDTH = 32;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic mem_read;
        logic mem_write;
    } ctrl_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_RSP = 1'b1
    } mem_state_e;

    // Byte enables for an access; funct3[1:0] encodes the size (byte/half/word).
    function automatic logic [3:0] lane_be(input logic [2:0] funct3, input logic [1:0] off);
        case (funct3[1:0])
            2'b00:   lane_be = 4'b0001 << off;
            2'b01:   lane_be = off[1] ? 4'b1100 : 4'b0011;
            default: lane_be = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/kamacore_load_align.sv
// Load data alignment: picks the addressed byte/half from the raw bus word and
// sign- or zero-extends it according to funct3.
module kamacore_load_align
    import kamacore_pkg::*;
(
    input  logic [CPU_WIDTH-1:0] rdata,
    input  logic [1:0]           off,
    input  logic [2:0]           funct3,
    output logic [CPU_WIDTH-1:0] result
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection from the byte offset within the word
    always_comb begin
        byte_s = 8'h00;
        case (off)
            2'b00:   byte_s = rdata[7:0];
            2'b01:   byte_s = rdata[15:8];
            2'b10:   byte_s = rdata[23:16];
            2'b11:   byte_s = rdata[31:24];
            default: byte_s = 8'h00;
        endcase
        half_s = off[1] ? rdata[31:16] : rdata[15:0];
    end

    // Extension by load type
    always_comb begin
        result = '0;
        case (funct3)
            F3_LB:   result = {{24{byte_s[7]}}, byte_s};
            F3_LBU:  result = {24'h000000, byte_s};
            F3_LH:   result = {{16{half_s[15]}}, half_s};
            F3_LHU:  result = {16'h0000, half_s};
            F3_LW:   result = rdata;
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/kamacore_stage_mem.sv
// Memory stage: EX/MEM -> data-memory port -> MEM/WB, with stall and response timeout.
// Optional build macro KAMACORE_MEM_MISALIGN_TRAP_EN traps misaligned accesses.
module kamacore_stage_mem
    import kamacore_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int RSP_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_mem_valid,
    input  logic [CPU_WIDTH-1:0]  ex_mem_alu_result,
    input  logic [CPU_WIDTH-1:0]  ex_mem_rs2_data,
    input  logic [31:0]           ex_mem_instruction,
    input  ctrl_t                 ex_mem_control_signals,
    output logic                  stall,
    output logic                  dmem_req_valid,
    input  logic                  dmem_req_ready,
    output logic [ADDR_WIDTH-1:0] dmem_req_addr,
    output logic                  dmem_req_we,
    output logic [3:0]            dmem_req_be,
    output logic [CPU_WIDTH-1:0]  dmem_req_wdata,
    input  logic                  dmem_rsp_valid,
    input  logic [CPU_WIDTH-1:0]  dmem_rsp_rdata,
    output logic                  mem_wb_valid,
    output logic [CPU_WIDTH-1:0]  mem_wb_result,
    output logic [31:0]           mem_wb_instruction,
    output ctrl_t                 mem_wb_control_signals,
    output logic                  mem_wb_bus_err
`ifdef KAMACORE_MEM_MISALIGN_TRAP_EN
    ,
    output logic                  mem_wb_misaligned
`endif
);

    localparam logic [7:0] TMO_LAST = 8'(RSP_TIMEOUT - 1);

    mem_state_e           state_r;
    logic [7:0]           tmo_cnt_r;
    logic [2:0]           funct3_s;
    logic                 is_mem_s;
    logic [1:0]           off_s;
    logic                 trap_s;
    logic                 req_valid_s;
    logic                 store_done_s;
    logic                 load_go_s;
    logic                 rsp_done_s;
    logic                 tmo_s;
    logic                 stall_s;
    logic [CPU_WIDTH-1:0] load_data_s;

    assign funct3_s = ex_mem_instruction[14:12];
    assign is_mem_s = ex_mem_valid & (ex_mem_control_signals.mem_read | ex_mem_control_signals.mem_write);

    // Effective byte offset: low bits that cannot be honoured for the size are dropped
    always_comb begin
        off_s = 2'b00;
        case (funct3_s[1:0])
            2'b00:   off_s = ex_mem_alu_result[1:0];
            2'b01:   off_s = {ex_mem_alu_result[1], 1'b0};
            default: off_s = 2'b00;
        endcase
    end

`ifdef KAMACORE_MEM_MISALIGN_TRAP_EN
    logic misalign_s;

    // Misalignment detect for half and word accesses
    always_comb begin
        misalign_s = 1'b0;
        case (funct3_s[1:0])
            2'b01:   misalign_s = ex_mem_alu_result[0];
            2'b10:   misalign_s = (ex_mem_alu_result[1:0] != 2'b00);
            default: misalign_s = 1'b0;
        endcase
    end

    assign trap_s = is_mem_s & (state_r == IDLE) & misalign_s;
`else
    assign trap_s = 1'b0;
`endif

    assign req_valid_s  = rst & (state_r == IDLE) & is_mem_s & ~trap_s;
    assign store_done_s = req_valid_s & dmem_req_ready & ex_mem_control_signals.mem_write;
    assign load_go_s    = req_valid_s & dmem_req_ready & ~ex_mem_control_signals.mem_write;
    assign rsp_done_s   = (state_r == WAIT_RSP) & dmem_rsp_valid;
    assign tmo_s        = (state_r == WAIT_RSP) & ~dmem_rsp_valid & (tmo_cnt_r == TMO_LAST);

    // Stall holds upstream until the access completes; gated by reset so outputs clear at once
    always_comb begin
        stall_s = 1'b0;
        if (!rst) begin
            stall_s = 1'b0;
        end else if (state_r == WAIT_RSP) begin
            stall_s = ~(rsp_done_s | tmo_s);
        end else begin
            stall_s = is_mem_s & ~(store_done_s | trap_s);
        end
    end

    assign stall = stall_s;

    // Request port drive: lane-aligned data, word-aligned address
    always_comb begin
        dmem_req_valid = 1'b0;
        dmem_req_addr  = '0;
        dmem_req_we    = 1'b0;
        dmem_req_be    = 4'b0000;
        dmem_req_wdata = '0;
        if (req_valid_s) begin
            dmem_req_valid = 1'b1;
            dmem_req_addr  = {ex_mem_alu_result[ADDR_WIDTH-1:2], 2'b00};
            dmem_req_we    = ex_mem_control_signals.mem_write;
            dmem_req_be    = lane_be(funct3_s, off_s);
            if (ex_mem_control_signals.mem_write) begin
                case (funct3_s[1:0])
                    2'b00:   dmem_req_wdata = {4{ex_mem_rs2_data[7:0]}};
                    2'b01:   dmem_req_wdata = {2{ex_mem_rs2_data[15:0]}};
                    default: dmem_req_wdata = ex_mem_rs2_data;
                endcase
            end else begin
                dmem_req_wdata = '0;
            end
        end else begin
            dmem_req_valid = 1'b0;
        end
    end

    kamacore_load_align u_load_align (
        .rdata  (dmem_rsp_rdata),
        .off    (off_s),
        .funct3 (funct3_s),
        .result (load_data_s)
    );

    // Access FSM, timeout counter and MEM/WB register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r                <= IDLE;
            tmo_cnt_r              <= 8'd0;
            mem_wb_valid           <= 1'b0;
            mem_wb_result          <= '0;
            mem_wb_instruction     <= 32'h0000_0000;
            mem_wb_control_signals <= '0;
            mem_wb_bus_err         <= 1'b0;
`ifdef KAMACORE_MEM_MISALIGN_TRAP_EN
            mem_wb_misaligned      <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    tmo_cnt_r <= 8'd0;
                    if (load_go_s) begin
                        state_r      <= WAIT_RSP;
                        mem_wb_valid <= 1'b0;
                    end else if (stall_s) begin
                        mem_wb_valid <= 1'b0;
                    end else begin
                        mem_wb_valid           <= ex_mem_valid;
                        mem_wb_result          <= ex_mem_alu_result;
                        mem_wb_instruction     <= ex_mem_instruction;
                        mem_wb_control_signals <= ex_mem_control_signals;
                        mem_wb_bus_err         <= 1'b0;
`ifdef KAMACORE_MEM_MISALIGN_TRAP_EN
                        mem_wb_misaligned      <= trap_s;
`endif
                    end
                end
                WAIT_RSP: begin
                    if (rsp_done_s || tmo_s) begin
                        state_r                <= IDLE;
                        tmo_cnt_r              <= 8'd0;
                        mem_wb_valid           <= 1'b1;
                        mem_wb_result          <= rsp_done_s ? load_data_s : '0;
                        mem_wb_instruction     <= ex_mem_instruction;
                        mem_wb_control_signals <= ex_mem_control_signals;
                        mem_wb_bus_err         <= ~rsp_done_s;
`ifdef KAMACORE_MEM_MISALIGN_TRAP_EN
                        mem_wb_misaligned      <= 1'b0;
`endif
                    end else begin
                        tmo_cnt_r    <= tmo_cnt_r + 8'd1;
                        mem_wb_valid <= 1'b0;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    tmo_cnt_r    <= 8'd0;
                    mem_wb_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
